gcd_job_dispatcher: RTL and testbench

Host-side initiator for the GCD engine (the go/done controller plus its subtract datapath). Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. Launches one engine job at a time with a single-cycle go pulse, waits for done, and returns each result over a valid/ready stream. Resolves zero-operand jobs locally, because the engine never terminates on a zero operand, and guards every launch with a timeout watchdog.

---
 rtl/gcd_job_dispatcher.sv | 180 ++++++++++++++++++
 tb/tb_gcd_job_dispatcher.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_job_dispatcher.sv
// gcd_job_dispatcher: queues operand pairs in a small FIFO and runs one GCD
// engine job at a time. Pairs with a zero operand are answered locally
// because the engine never terminates on them. Every launch is guarded by a
// watchdog; a timeout returns an error result and halts the block until reset.
module gcd_job_dispatcher #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_a_i,
  input  logic [WIDTH-1:0]           in_b_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_result_o,
  output logic                       out_err_o,
  output logic                       gcd_go_o,
  output logic [WIDTH-1:0]           gcd_a_o,
  output logic [WIDTH-1:0]           gcd_b_o,
  input  logic                       gcd_done_i,
  input  logic [WIDTH-1:0]           gcd_result_i,
  output logic                       fault_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);
  localparam logic [TW-1:0] LastTick  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP,
    S_HALT
  } state_e;

  state_e             state_q;
  logic [2*WIDTH-1:0] fifoMem_q [DEPTH];
  logic [PW-1:0]      wrPtr_q, wrPtr_d;
  logic [PW-1:0]      rdPtr_q, rdPtr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [TW-1:0]      wdCount_q;
  logic               fault_q;
  logic               outValid_q;
  logic               outErr_q;
  logic [WIDTH-1:0]   outResult_q;
  logic               gcdGo_q;
  logic [WIDTH-1:0]   gcdA_q;
  logic [WIDTH-1:0]   gcdB_q;

  logic               pushEn;
  logic               popEn;
  logic [WIDTH-1:0]   headA;
  logic [WIDTH-1:0]   headB;

  // A sticky fault blocks new input so queued work is kept intact for debug.
  assign in_ready_o = (count_q != FullCount) && !fault_q;
  assign pushEn     = in_valid_i && in_ready_o;
  assign popEn      = (state_q == S_IDLE) && (count_q != '0) && !fault_q;
  assign headA      = fifoMem_q[rdPtr_q][2*WIDTH-1:WIDTH];
  assign headB      = fifoMem_q[rdPtr_q][WIDTH-1:0];

  assign out_valid_o  = outValid_q;
  assign out_err_o    = outErr_q;
  assign out_result_o = outResult_q;
  assign gcd_go_o     = gcdGo_q;
  assign gcd_a_o      = gcdA_q;
  assign gcd_b_o      = gcdB_q;
  assign fault_o      = fault_q;
  assign occupancy_o  = count_q;

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      fifoMem_q[wrPtr_q] <= {in_a_i, in_b_i};
    end
  end

  // Next pointers and count; power-of-two depth lets the pointers wrap freely.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushEn) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (popEn) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end
    if (pushEn && !popEn) begin
      count_d = count_q + CW'(1);
    end else if (!pushEn && popEn) begin
      count_d = count_q - CW'(1);
    end
  end

  // FIFO pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Job sequencer: pop, bypass or launch, wait with watchdog, hand result out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wdCount_q   <= '0;
      fault_q     <= 1'b0;
      outValid_q  <= 1'b0;
      outErr_q    <= 1'b0;
      outResult_q <= '0;
      gcdGo_q     <= 1'b0;
      gcdA_q      <= '0;
      gcdB_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (popEn) begin
            if (headA == '0 || headB == '0) begin
              outResult_q <= headA | headB;
              outErr_q    <= 1'b0;
              outValid_q  <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              gcdA_q  <= headA;
              gcdB_q  <= headB;
              gcdGo_q <= 1'b1;
              state_q <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          gcdGo_q   <= 1'b0;
          wdCount_q <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          wdCount_q <= wdCount_q + TW'(1);
          if (gcd_done_i) begin
            outResult_q <= gcd_result_i;
            outErr_q    <= 1'b0;
            outValid_q  <= 1'b1;
            state_q     <= S_RESP;
          end else if (wdCount_q == LastTick) begin
            outResult_q <= '0;
            outErr_q    <= 1'b1;
            outValid_q  <= 1'b1;
            fault_q     <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (out_ready_i) begin
            outValid_q <= 1'b0;
            state_q    <= fault_q ? S_HALT : S_IDLE;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_job_dispatcher.sv
// tb_gcd_job_dispatcher: directed vectors for the GCD job dispatcher with a
// hand-driven engine; expected results are hand-computed constants.
`timescale 1ns/1ps
module tb_gcd_job_dispatcher;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_result;
  logic             out_err;
  logic             gcd_go;
  logic [WIDTH-1:0] gcd_a;
  logic [WIDTH-1:0] gcd_b;
  logic             gcd_done = 1'b0;
  logic [WIDTH-1:0] gcd_result = '0;
  logic             fault;
  logic [CW-1:0]    occupancy;

  int checks  = 0;
  int errors  = 0;
  int goCount = 0;
  int goMark;

  gcd_job_dispatcher #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .out_err_o    (out_err),
    .gcd_go_o     (gcd_go),
    .gcd_a_o      (gcd_a),
    .gcd_b_o      (gcd_b),
    .gcd_done_i   (gcd_done),
    .gcd_result_i (gcd_result),
    .fault_o      (fault),
    .occupancy_o  (occupancy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // count engine launch pulses
  always @(posedge clk) begin
    if (gcd_go) goCount <= goCount + 1;
  end

  // overall time limit
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got 0 expected 1");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // step past the next rising edge; outputs are then settled for sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // offer one pair and wait (bounded) until it is taken
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) checkOutput("push_accept", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // wait (bounded) for a launch pulse
  task automatic waitGo(input int budget);
    int n;
    n = 0;
    while (!gcd_go && n < budget) begin
      tick();
      n++;
    end
    checkOutput("go_seen", gcd_go, 1);
  endtask

  // from the LAUNCH cycle: enter WAIT, hold for delay cycles, then pulse done
  task automatic respondEngine(input int delay, input logic [WIDTH-1:0] res,
                               input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb);
    bit holdOk;
    holdOk = 1'b1;
    tick();
    for (int i = 0; i <= delay; i++) begin
      if (gcd_go !== 1'b0 || gcd_a !== ea || gcd_b !== eb || out_valid !== 1'b0) holdOk = 1'b0;
      if (i < delay) tick();
    end
    checkOutput("engine_hold", holdOk, 1);
    gcd_done = 1'b1;
    gcd_result = res;
    tick();
    gcd_done = 1'b0;
    gcd_result = '0;
    checkOutput("done_to_valid", out_valid, 1);
  endtask

  // wait (bounded) for a result, compare it and accept it
  task automatic collectResult(input string tag, input int expRes, input int expErr);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_result"}, out_result, expRes);
    checkOutput({tag, "_err"}, out_err, expErr);
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_released"}, out_valid, 0);
  endtask

  initial begin
    $display("[TB] start");

    // reset values
    repeat (3) tick();
    checkOutput("rst_occupancy", occupancy, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_err", out_err, 0);
    checkOutput("rst_out_result", out_result, 0);
    checkOutput("rst_fault", fault, 0);
    checkOutput("rst_gcd_go", gcd_go, 0);
    checkOutput("rst_gcd_a", gcd_a, 0);
    checkOutput("rst_gcd_b", gcd_b, 0);
    rst = 1'b0;
    tick();
    checkOutput("rst_in_ready", in_ready, 1);

    // basic engine job: gcd(12,18)=6
    goMark = goCount;
    applyStimulus(8'd12, 8'd18);
    checkOutput("basic_occ", occupancy, 1);
    waitGo(5);
    checkOutput("basic_gcd_a", gcd_a, 12);
    checkOutput("basic_gcd_b", gcd_b, 18);
    respondEngine(10, 8'd6, 8'd12, 8'd18);
    collectResult("basic", 6, 0);
    checkOutput("basic_go_count", goCount - goMark, 1);

    // zero bypass: (0,9)->9, (7,0)->7, (0,0)->0 with out_valid at pop+1
    goMark = goCount;
    out_ready = 1'b1;
    applyStimulus(8'd0, 8'd9);
    checkOutput("byp_occ0", occupancy, 1);
    checkOutput("byp_valid0", out_valid, 0);
    applyStimulus(8'd7, 8'd0);
    checkOutput("byp_valid1", out_valid, 1);
    checkOutput("byp_result1", out_result, 9);
    checkOutput("byp_occ1", occupancy, 1);
    applyStimulus(8'd0, 8'd0);
    checkOutput("byp_valid2", out_valid, 0);
    checkOutput("byp_occ2", occupancy, 2);
    tick();
    checkOutput("byp_valid3", out_valid, 1);
    checkOutput("byp_result3", out_result, 7);
    tick();
    checkOutput("byp_valid4", out_valid, 0);
    tick();
    checkOutput("byp_valid5", out_valid, 1);
    checkOutput("byp_result5", out_result, 0);
    checkOutput("byp_err5", out_err, 0);
    tick();
    checkOutput("byp_valid6", out_valid, 0);
    out_ready = 1'b0;
    checkOutput("byp_no_go", goCount - goMark, 0);

    // back-pressure and full FIFO
    goMark = goCount;
    applyStimulus(8'd8, 8'd12);
    applyStimulus(8'd9, 8'd6);
    applyStimulus(8'd5, 8'd5);
    applyStimulus(8'd14, 8'd21);
    checkOutput("full_ready5", in_ready, 1);
    applyStimulus(8'd20, 8'd15);
    checkOutput("full_occ", occupancy, 4);
    in_valid = 1'b1;
    in_a = 8'd27;
    in_b = 8'd18;
    for (int i = 0; i < 3; i++) begin
      checkOutput("full_ready6", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    checkOutput("full_occ_hold", occupancy, 4);
    checkOutput("full_go_count", goCount - goMark, 1);
    gcd_done = 1'b1;
    gcd_result = 8'd4;
    tick();
    gcd_done = 1'b0;
    gcd_result = '0;
    tick();
    checkOutput("bp_valid_held", out_valid, 1);
    checkOutput("bp_result_held", out_result, 4);
    collectResult("order0", 4, 0);
    waitGo(5);
    respondEngine(3, 8'd3, 8'd9, 8'd6);
    collectResult("order1", 3, 0);
    waitGo(5);
    respondEngine(3, 8'd5, 8'd5, 8'd5);
    collectResult("order2", 5, 0);
    waitGo(5);
    respondEngine(3, 8'd7, 8'd14, 8'd21);
    collectResult("order3", 7, 0);
    waitGo(5);
    respondEngine(3, 8'd5, 8'd20, 8'd15);
    collectResult("order4", 5, 0);
    repeat (4) tick();
    checkOutput("order_drained_occ", occupancy, 0);
    checkOutput("order_drained_valid", out_valid, 0);

    // timeout: engine never answers
    applyStimulus(8'd10, 8'd4);
    waitGo(5);
    tick();
    applyStimulus(8'd6, 8'd4);
    repeat (14) tick();
    checkOutput("to_before_valid", out_valid, 0);
    checkOutput("to_before_fault", fault, 0);
    tick();
    checkOutput("to_valid", out_valid, 1);
    checkOutput("to_err", out_err, 1);
    checkOutput("to_result", out_result, 0);
    checkOutput("to_fault", fault, 1);
    checkOutput("to_in_ready", in_ready, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    goMark = goCount;
    repeat (8) tick();
    checkOutput("halt_no_go", goCount - goMark, 0);
    checkOutput("halt_occ", occupancy, 1);
    checkOutput("halt_valid", out_valid, 0);
    checkOutput("halt_fault", fault, 1);
    rst = 1'b1;
    #1;
    checkOutput("to_rst_fault", fault, 0);
    checkOutput("to_rst_occ", occupancy, 0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("to_rst_ready", in_ready, 1);

    // done coinciding with the final watchdog cycle: done wins
    applyStimulus(8'd9, 8'd6);
    waitGo(5);
    respondEngine(TIMEOUT - 1, 8'd3, 8'd9, 8'd6);
    checkOutput("tie_fault", fault, 0);
    collectResult("tie", 3, 0);
    checkOutput("tie_ready", in_ready, 1);

    // reset in WAIT, then a late done must be ignored
    applyStimulus(8'd21, 8'd14);
    waitGo(5);
    tick();
    applyStimulus(8'd3, 8'd3);
    checkOutput("mid_occ_before", occupancy, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_occ", occupancy, 0);
    tick();
    rst = 1'b0;
    goMark = goCount;
    gcd_done = 1'b1;
    gcd_result = 8'd7;
    tick();
    gcd_done = 1'b0;
    gcd_result = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    checkOutput("mid_late_valid", out_valid, 0);
    checkOutput("mid_late_occ", occupancy, 0);
    checkOutput("mid_late_go", goCount - goMark, 0);
    out_ready = 1'b0;
    applyStimulus(8'd21, 8'd14);
    waitGo(5);
    respondEngine(4, 8'd7, 8'd21, 8'd14);
    collectResult("mid_again", 7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
